// File: rtl/posit_mac_acc_pkg.sv
// Shared posit constants, operand class encodings and scale helpers.
// The posit decoder imports the same package, so widths stay in lockstep.
package posit_pkg;
  localparam int P_WIDTH = 8;
  localparam int P_EXP   = 2;
  localparam int P_GUARD = 8;

  localparam int MTS   = P_WIDTH - 3 - P_EXP;
  localparam int SMAX  = (2 ** P_EXP) * (P_WIDTH - 2);
  localparam int FRAC  = 2 * MTS + 2 * SMAX;
  localparam int QW    = FRAC + 2 * SMAX + 2 + P_GUARD + 1;
  localparam int RGW   = $clog2(P_WIDTH) + 1;
  localparam int SCL_W = $clog2(2 * SMAX) + 2;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    NORM = 2'b01,
    NAR  = 2'b10
  } cls_e;

  function automatic logic cls_zero(input logic [1:0] c);
    return c == ZERO;
  endfunction

  function automatic logic cls_nar(input logic [1:0] c);
    return c == NAR;
  endfunction

  // sext(k)*2^EXP + e is a plain concatenation because e < 2^EXP.
  function automatic logic signed [SCL_W-1:0] scale(input logic [RGW-1:0] k,
                                                    input logic [P_EXP-1:0] e);
    return $signed({{(SCL_W - RGW - P_EXP){k[RGW-1]}}, k, e});
  endfunction
endpackage

// File: rtl/posit_mac_acc_if.sv
// Decoded-operand stream into the MAC and the exact-sum result back out.
interface posit_mac_acc_if
  import posit_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int EXP   = P_EXP,
  parameter int GUARD = P_GUARD
);
  localparam int L_MTS  = WIDTH - 3 - EXP;
  localparam int L_SMAX = (2 ** EXP) * (WIDTH - 2);
  localparam int L_QW   = 2 * L_MTS + 4 * L_SMAX + 2 + GUARD + 1;
  localparam int L_RGW  = $clog2(WIDTH) + 1;

  logic             vld_i;
  logic             last_i;
  logic             clr_i;
  logic             sign_s;
  logic             sign_l;
  logic [L_RGW-1:0] regi_s;
  logic [L_RGW-1:0] regi_l;
  logic [EXP-1:0]   exp_s;
  logic [EXP-1:0]   exp_l;
  logic [L_MTS-1:0] mts_s;
  logic [L_MTS-1:0] mts_l;
  logic [1:0]       vld_o_w;
  logic [1:0]       vld_o_d;
  logic [L_QW-1:0]  acc_o;
  logic             acc_vld_o;
  logic             nar_o;
  logic             ovf_o;
  logic             busy_o;

  modport master (
    output vld_i, last_i, clr_i, sign_s, sign_l, regi_s, regi_l,
           exp_s, exp_l, mts_s, mts_l, vld_o_w, vld_o_d,
    input  acc_o, acc_vld_o, nar_o, ovf_o, busy_o
  );

  modport slave (
    input  vld_i, last_i, clr_i, sign_s, sign_l, regi_s, regi_l,
           exp_s, exp_l, mts_s, mts_l, vld_o_w, vld_o_d,
    output acc_o, acc_vld_o, nar_o, ovf_o, busy_o
  );
endinterface

// File: rtl/posit_mac_acc_prod_align.sv
// Places an exact posit product into quire coordinates as a signed term.
// Zero and NaR products contribute nothing; NaR is tracked by a flag instead.
module posit_prod_align
  import posit_pkg::*;
#(
  parameter int QW_P   = QW,
  parameter int SCL_P  = SCL_W,
  parameter int PMW_P  = 2 * MTS + 2,
  parameter int SMAX_P = SMAX
) (
  input  logic                    i_psign,
  input  logic signed [SCL_P-1:0] i_pscale,
  input  logic [PMW_P-1:0]        i_pmant,
  input  logic                    i_pzero,
  input  logic                    i_pnar,
  output logic [QW_P-1:0]         o_term
);
  logic [SCL_P-1:0] w_sh;
  logic [QW_P-1:0]  w_mag;

  // Biasing by 2*SMAX maps the smallest product onto bit 0 of the quire.
  assign w_sh  = $unsigned(i_pscale) + SCL_P'(2 * SMAX_P);
  assign w_mag = QW_P'(i_pmant) << w_sh;

  always_comb begin
    o_term = w_mag;
    if (i_pzero || i_pnar) begin
      o_term = '0;
    end else if (i_psign) begin
      o_term = -w_mag;
    end
  end
endmodule

// File: rtl/posit_mac_acc.sv
// Exact posit dot-product accumulator: product register, aligned-term register,
// then a wide two's-complement quire with sticky NaR/overflow per vector.
module posit_mac_acc
  import posit_pkg::*;
#(
  parameter int WIDTH = P_WIDTH,
  parameter int EXP   = P_EXP,
  parameter int GUARD = P_GUARD
) (
  input logic            clk_i,
  input logic            rstn,
  posit_mac_acc_if.slave bus
);
  localparam int L_MTS  = WIDTH - 3 - EXP;
  localparam int L_SMAX = (2 ** EXP) * (WIDTH - 2);
  localparam int L_FRAC = 2 * L_MTS + 2 * L_SMAX;
  localparam int L_QW   = L_FRAC + 2 * L_SMAX + 2 + GUARD + 1;
  localparam int L_SCL  = $clog2(2 * L_SMAX) + 2;
  localparam int L_PMW  = 2 * L_MTS + 2;

  logic                    r_s1_vld, r_s1_last, r_s1_sign, r_s1_zero, r_s1_nar;
  logic signed [L_SCL-1:0] r_s1_scale;
  logic [L_PMW-1:0]        r_s1_mant;
  logic                    r_s2_vld, r_s2_last, r_s2_nar;
  logic [L_QW-1:0]         r_s2_term;
  logic [L_QW-1:0]         r_quire;
  logic [L_QW-1:0]         r_acc;
  logic                    r_ovf_st, r_nar_st;
  logic                    r_acc_vld, r_nar, r_ovf, r_busy;
  logic [L_QW-1:0]         w_term;
  logic [L_QW-1:0]         w_sum;
  logic                    w_ovf_now;
  logic                    w_result;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_scale <= '0;
      r_s1_mant  <= '0;
    end else if (bus.clr_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_vld  <= bus.vld_i;
      r_s1_last <= bus.vld_i & bus.last_i;
      if (bus.vld_i) begin
        r_s1_sign  <= bus.sign_s ^ bus.sign_l;
        r_s1_scale <= scale(bus.regi_s, bus.exp_s) + scale(bus.regi_l, bus.exp_l);
        r_s1_mant  <= L_PMW'({1'b1, bus.mts_s}) * L_PMW'({1'b1, bus.mts_l});
        r_s1_zero  <= cls_zero(bus.vld_o_w) | cls_zero(bus.vld_o_d);
        r_s1_nar   <= cls_nar(bus.vld_o_w) | cls_nar(bus.vld_o_d);
      end
    end
  end

  posit_prod_align #(
    .QW_P  (L_QW),
    .SCL_P (L_SCL),
    .PMW_P (L_PMW),
    .SMAX_P(L_SMAX)
  ) u_align (
    .i_psign (r_s1_sign),
    .i_pscale(r_s1_scale),
    .i_pmant (r_s1_mant),
    .i_pzero (r_s1_zero),
    .i_pnar  (r_s1_nar),
    .o_term  (w_term)
  );

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_nar  <= 1'b0;
      r_s2_term <= '0;
    end else if (bus.clr_i) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_vld & r_s1_last;
      if (r_s1_vld) begin
        r_s2_term <= w_term;
        r_s2_nar  <= r_s1_nar;
      end
    end
  end

  assign w_sum     = r_quire + r_s2_term;
  assign w_ovf_now = r_s2_vld & (r_quire[L_QW-1] == r_s2_term[L_QW-1])
                              & (w_sum[L_QW-1] != r_quire[L_QW-1]);
  assign w_result  = r_s2_vld & r_s2_last;

  // A finishing vector hands its sum out and restarts the quire on the same edge.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_quire   <= '0;
      r_ovf_st  <= 1'b0;
      r_nar_st  <= 1'b0;
      r_acc     <= '0;
      r_acc_vld <= 1'b0;
      r_nar     <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
    end else if (bus.clr_i) begin
      r_quire   <= '0;
      r_ovf_st  <= 1'b0;
      r_nar_st  <= 1'b0;
      r_acc_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_acc_vld <= w_result;
      r_busy    <= bus.vld_i | (w_result ? r_s1_vld : r_busy);
      if (w_result) begin
        r_acc    <= w_sum;
        r_nar    <= r_nar_st | r_s2_nar;
        r_ovf    <= r_ovf_st | w_ovf_now;
        r_quire  <= '0;
        r_ovf_st <= 1'b0;
        r_nar_st <= 1'b0;
      end else if (r_s2_vld) begin
        r_quire  <= w_sum;
        r_ovf_st <= r_ovf_st | w_ovf_now;
        r_nar_st <= r_nar_st | r_s2_nar;
      end
    end
  end

  assign bus.acc_o     = r_acc;
  assign bus.acc_vld_o = r_acc_vld;
  assign bus.nar_o     = r_nar;
  assign bus.ovf_o     = r_ovf;
  assign bus.busy_o    = r_busy;
endmodule

// File: tb/tb_posit_mac_acc.sv
// Bench for posit_mac_acc: real-valued product model with an exact quire,
// per-cycle output comparison, and directed literal checks on key vectors.
module tb_posit_mac_acc;
  import posit_pkg::*;

  typedef struct {
    logic       s;
    int         k;
    int         e;
    int         m;
    logic [1:0] cls;
  } op_t;

  typedef struct {
    int                 commit;
    logic signed [QW-1:0] term;
    logic               nar;
    logic               last;
  } pend_t;

  typedef struct {
    logic [QW-1:0] acc;
    logic          nar;
    logic          ovf;
    int            cyc;
  } res_t;

  logic clk_i;
  logic rstn;
  posit_mac_acc_if bus ();

  posit_mac_acc dut (
    .clk_i(clk_i),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int tcyc   = 0;
  int mcyc   = 0;

  always @(posedge clk_i) tcyc++;

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [QW-1:0] one_sh(input int n);
    logic [QW-1:0] r;
    r = 1;
    return r << n;
  endfunction

  function automatic op_t mk(input logic s, input int k, input int e, input int m,
                             input logic [1:0] cls);
    op_t o;
    o.s = s; o.k = k; o.e = e; o.m = m; o.cls = cls;
    return o;
  endfunction

  // Value of each operand is (1 + m/2^MTS) * 2^(k*2^EXP + e); the quire counts
  // in units of 2^-FRAC, so the product lands at mant_a*mant_b * 2^(scale + FRAC - 2*MTS).
  function automatic logic signed [QW-1:0] model_term(input op_t a, input op_t b);
    int sa, sb, mag, sh;
    logic signed [QW-1:0] t;
    if (a.cls != NORM || b.cls != NORM) return '0;
    sa  = a.k * (2 ** P_EXP) + a.e;
    sb  = b.k * (2 ** P_EXP) + b.e;
    mag = ((1 << MTS) + a.m) * ((1 << MTS) + b.m);
    sh  = sa + sb + FRAC - 2 * MTS;
    t   = QW'(mag);
    t   = t <<< sh;
    if (a.s ^ b.s) t = -t;
    return t;
  endfunction

  // Reference model state
  pend_t                 pend[$];
  logic signed [QW-1:0]  m_q;
  logic                  m_ovf, m_nar;
  int                    m_cnt;
  logic [QW-1:0]         exp_acc;
  logic                  exp_vld, exp_nar, exp_ovf, exp_busy;
  logic signed [QW+1:0]  q_max, q_min, wide;
  op_t                   cur_a, cur_b;

  initial begin
    q_max = (QW+2)'(1) <<< (QW - 1);
    q_max = q_max - 1;
    q_min = -q_max - 1;
    m_q = '0; m_ovf = 0; m_nar = 0; m_cnt = 0;
    exp_acc = '0; exp_vld = 0; exp_nar = 0; exp_ovf = 0; exp_busy = 0;
  end

  always @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      pend.delete();
      m_q = '0; m_ovf = 0; m_nar = 0; m_cnt = 0;
      exp_acc = '0; exp_vld = 0; exp_nar = 0; exp_ovf = 0; exp_busy = 0;
    end else begin
      mcyc++;
      exp_vld = 0;
      if (bus.clr_i) begin
        pend.delete();
        m_q = '0; m_ovf = 0; m_nar = 0; m_cnt = 0;
      end else begin
        while (pend.size() > 0 && pend[0].commit == mcyc) begin
          pend_t e;
          e = pend.pop_front();
          wide = m_q;
          wide = wide + e.term;
          if (wide > q_max || wide < q_min) m_ovf = 1;
          m_q   = wide[QW-1:0];
          m_nar = m_nar | e.nar;
          m_cnt++;
          if (e.last) begin
            exp_acc = m_q; exp_nar = m_nar; exp_ovf = m_ovf; exp_vld = 1;
            m_q = '0; m_ovf = 0; m_nar = 0; m_cnt = 0;
          end
        end
        if (bus.vld_i) begin
          pend_t n;
          n.commit = mcyc + 2;
          n.term   = model_term(cur_a, cur_b);
          n.nar    = (cur_a.cls == NAR) || (cur_b.cls == NAR);
          n.last   = bus.last_i;
          pend.push_back(n);
        end
      end
      exp_busy = (pend.size() > 0) || (m_cnt > 0);
    end
  end

  always @(negedge clk_i) begin
    if (rstn) begin
      chk("acc_vld_o", QW'(bus.acc_vld_o), QW'(exp_vld));
      chk("acc_o",     bus.acc_o,          exp_acc);
      chk("nar_o",     QW'(bus.nar_o),     QW'(exp_nar));
      chk("ovf_o",     QW'(bus.ovf_o),     QW'(exp_ovf));
      chk("busy_o",    QW'(bus.busy_o),    QW'(exp_busy));
    end
  end

  res_t mon[$];
  always @(negedge clk_i) begin
    if (rstn && bus.acc_vld_o)
      mon.push_back('{acc: bus.acc_o, nar: bus.nar_o, ovf: bus.ovf_o, cyc: tcyc});
  end

  task automatic drive(input logic v, input logic l, input logic c, input op_t a, input op_t b);
    cur_a = a; cur_b = b;
    bus.vld_i  = v;  bus.last_i = l;  bus.clr_i = c;
    bus.sign_s = a.s; bus.regi_s = RGW'(a.k); bus.exp_s = P_EXP'(a.e);
    bus.mts_s  = MTS'(a.m); bus.vld_o_w = a.cls;
    bus.sign_l = b.s; bus.regi_l = RGW'(b.k); bus.exp_l = P_EXP'(b.e);
    bus.mts_l  = MTS'(b.m); bus.vld_o_d = b.cls;
    @(posedge clk_i);
    #1;
  endtask

  op_t ONE, NEG1, TWO, ONE5, TINY, BIG, ZOP, NOP;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, ONE, ONE);
  endtask

  function automatic op_t rnd_op();
    int r;
    logic [1:0] c;
    r = int'($urandom_range(0, 9));
    c = (r == 0) ? ZERO : (r == 1) ? NAR : NORM;
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)) - 6,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), c);
  endfunction

  int t_last;

  initial begin
    ONE  = mk(0, 0, 0, 0, NORM);
    NEG1 = mk(1, 0, 0, 0, NORM);
    TWO  = mk(0, 0, 1, 0, NORM);
    ONE5 = mk(0, 0, 0, 4, NORM);
    TINY = mk(0, -6, 0, 0, NORM);
    BIG  = mk(0, 5, 3, 7, NORM);
    ZOP  = mk(0, 0, 0, 0, ZERO);
    NOP  = mk(0, 0, 0, 0, NAR);
    cur_a = ONE; cur_b = ONE;
    rstn = 1'b0;
    bus.vld_i = 0; bus.last_i = 0; bus.clr_i = 0;
    bus.sign_s = 0; bus.regi_s = '0; bus.exp_s = '0; bus.mts_s = '0; bus.vld_o_w = NORM;
    bus.sign_l = 0; bus.regi_l = '0; bus.exp_l = '0; bus.mts_l = '0; bus.vld_o_d = NORM;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_acc",  bus.acc_o, '0);
    chk("rst_vld",  QW'(bus.acc_vld_o), '0);
    chk("rst_nar",  QW'(bus.nar_o), '0);
    chk("rst_ovf",  QW'(bus.ovf_o), '0);
    chk("rst_busy", QW'(bus.busy_o), '0);
    @(posedge clk_i);
    #1 rstn = 1'b1;

    // 1.0 x 1.0 single-term vector, latency two edges
    mon.delete();
    drive(1, 1, 0, ONE, ONE);
    t_last = tcyc;
    idle(4);
    chk("t1_pulses", QW'(mon.size()), QW'(1));
    if (mon.size() > 0) begin
      chk("t1_acc", mon[0].acc, one_sh(54));
      chk("t1_lat", QW'(mon[0].cyc), QW'(t_last + 2));
      chk("t1_nar", QW'(mon[0].nar), '0);
      chk("t1_ovf", QW'(mon[0].ovf), '0);
    end

    // 2.0 x 1.5
    mon.delete();
    drive(1, 1, 0, TWO, ONE5);
    idle(4);
    chk("t2_pulses", QW'(mon.size()), QW'(1));
    if (mon.size() > 0) chk("t2_acc", mon[0].acc, one_sh(54) * 3);

    // four-term vector followed immediately by a one-term negative vector
    mon.delete();
    for (int i = 0; i < 4; i++) drive(1, i == 3, 0, ONE, ONE);
    drive(1, 1, 0, NEG1, ONE);
    idle(5);
    chk("t3_pulses", QW'(mon.size()), QW'(2));
    if (mon.size() == 2) begin
      chk("t3_acc0", mon[0].acc, one_sh(54) * 4);
      chk("t3_acc1", mon[1].acc, -one_sh(54));
      chk("t3_gap",  QW'(mon[1].cyc - mon[0].cyc), QW'(1));
    end

    // smallest magnitudes, then many largest magnitudes to force overflow
    mon.delete();
    drive(1, 1, 0, TINY, TINY);
    idle(4);
    if (mon.size() > 0) chk("t4_tiny", mon[0].acc, one_sh(6));
    else chk("t4_tiny_pulse", '0, QW'(1));
    mon.delete();
    for (int i = 0; i < 1200; i++) drive(1, i == 1199, 0, BIG, BIG);
    idle(4);
    chk("t4_pulses", QW'(mon.size()), QW'(1));
    if (mon.size() > 0) chk("t4_ovf", QW'(mon[0].ovf), QW'(1));

    // zero and NaR classes
    mon.delete();
    drive(1, 0, 0, ONE, ONE);
    drive(1, 0, 0, ZOP, ONE);
    drive(1, 1, 0, ONE, ONE);
    drive(1, 0, 0, ONE, ONE);
    drive(1, 0, 0, ONE, NOP);
    drive(1, 1, 0, ONE, ONE);
    idle(4);
    chk("t5_pulses", QW'(mon.size()), QW'(2));
    if (mon.size() == 2) begin
      chk("t5_acc0", mon[0].acc, one_sh(55));
      chk("t5_nar0", QW'(mon[0].nar), '0);
      chk("t5_acc1", mon[1].acc, one_sh(55));
      chk("t5_nar1", QW'(mon[1].nar), QW'(1));
    end

    // clear one and two cycles behind a last term
    mon.delete();
    drive(1, 1, 0, ONE, ONE);
    drive(0, 0, 1, ONE, ONE);
    idle(3);
    drive(1, 0, 0, ONE, ONE);
    drive(1, 1, 0, ONE, ONE);
    idle(1);
    drive(0, 0, 1, ONE, ONE);
    idle(3);
    chk("t6_pulses", QW'(mon.size()), '0);
    chk("t6_acc_hold", bus.acc_o, one_sh(55));
    chk("t6_nar_hold", QW'(bus.nar_o), QW'(1));

    // clear together with a valid term drops that term
    mon.delete();
    drive(1, 0, 1, BIG, BIG);
    drive(1, 1, 0, ONE5, TWO);
    idle(4);
    if (mon.size() > 0) chk("t7_acc", mon[0].acc, one_sh(54) * 3);
    else chk("t7_pulse", '0, QW'(1));

    // reset in the middle of a vector
    drive(1, 0, 0, TWO, TWO);
    drive(1, 0, 0, TWO, TWO);
    bus.vld_i = 0;
    rstn = 1'b0;
    @(negedge clk_i);
    chk("t8_acc",  bus.acc_o, '0);
    chk("t8_busy", QW'(bus.busy_o), '0);
    chk("t8_nar",  QW'(bus.nar_o), '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rstn = 1'b1;
    mon.delete();
    drive(1, 1, 0, ONE, ONE5);
    idle(4);
    if (mon.size() > 0) chk("t8_acc_after", mon[0].acc, one_sh(53) * 3);
    else chk("t8_pulse", '0, QW'(1));

    // last on every cycle
    mon.delete();
    for (int i = 0; i < 20; i++) drive(1, 1, 0, rnd_op(), rnd_op());
    idle(4);
    chk("t9_pulses", QW'(mon.size()), QW'(20));

    // random traffic against the model
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
            $urandom_range(0, 39) == 0, rnd_op(), rnd_op());
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
